sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the successor to the existing SYN_FIFO. It uses separate read and write pointers instead of a single counter-addressed store, so ordering is true first-in-first-out. It adds an occupancy count, programmable almost-full and almost-empty thresholds, overflow and underflow pulses, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between datapath stages as the team's standard elastic buffer.

Parameters:
DATA_W, 128, data width in bits (≥1)
DEPTH, 1024, number of entries; must be a power of two and ≥4
UPP_TH, 4, almost-full asserts when free entries ≤ UPP_TH
LOW_TH, 2, almost-empty asserts when occupancy ≤ LOW_TH
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through
Derived: AW = log2(DEPTH); CW = AW+1

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
i_flush  in  1  synchronous clear of pointers and count
i_wren  in  1  write request
i_wrdata  in  DATA_W  write data
i_rden  in  1  read request
o_rddata  out  DATA_W  read data
o_rdvalid  out  1  o_rddata holds valid popped/head data
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_almost_full  out  1  count ≥ DEPTH-UPP_TH
o_almost_empty  out  1  count ≤ LOW_TH
o_count  out  CW  current occupancy, 0..DEPTH
o_overflow  out  1  1-cycle pulse: write rejected
o_underflow  out  1  1-cycle pulse: read rejected

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=rd_ptr=0, count=0, o_rddata=0, o_rdvalid=0, o_overflow=o_underflow=0. Resulting flags: o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0. The storage array is not reset. Release is synchronous to clk.
- Pointers are AW bits wide and wrap naturally from DEPTH-1 to 0. The count is a separate CW-bit register. All flags decode combinationally from the count.
- Read accepted: rd_ok = i_rden & ~o_empty.
- Write accepted: wr_ok = i_wrdata path enabled when i_wren & (~o_full | rd_ok).
- Full with simultaneous read and write: both are accepted; count stays DEPTH.
- Empty with simultaneous read and write: the write is accepted and the read is rejected (o_underflow pulses). The written word is not bypassed to the output.
- Count update: +1 on wr_ok only, −1 on rd_ok only, unchanged on both or neither.
- o_overflow is registered, high for one cycle after i_wren & ~wr_ok.
- o_underflow is registered, high for one cycle after i_rden & ~rd_ok.
- FWFT=0: on rd_ok, mem[rd_ptr] is registered to o_rddata and o_rdvalid=1 the next cycle. Otherwise o_rdvalid=0 and o_rddata holds its last value.
- FWFT=1: o_rddata shows mem[rd_ptr] whenever count>0, and o_rdvalid = ~o_empty. i_rden acknowledges and pops the head. A word written into an empty FIFO appears on o_rddata one cycle after the write.
- i_flush=1 (synchronous): pointers and count go to 0, o_rdvalid=0. Any concurrent i_wren/i_rden is ignored and no error pulse is raised. i_flush has priority over both.
- Reset asserted mid-operation clears state immediately. Stored data is considered lost.

Test Plan:
- DEPTH=16, DATA_W=8, FWFT=0: write 0x01..0x10 -> o_full=1 and o_count=16; o_almost_full first asserts at count=12; 17th write -> o_overflow pulse and count stays 16.
- Same config: read 16 times -> o_rddata returns 0x01..0x10 in order, each one cycle after i_rden. o_almost_empty asserts at count=2, o_empty at 0. A 17th read -> o_underflow pulse.
- Full FIFO, i_wren=i_rden=1 with data 0xAA -> o_count stays 16, 0x01 is read, and 0xAA lands at the tail (read out last after draining).
- Empty FIFO, simultaneous read+write of 0x55 -> o_underflow pulse and count=1. The next read returns 0x55.
- FWFT=1: write 0x3C into an empty FIFO -> o_rddata=0x3C and o_rdvalid=1 the following cycle with no read issued. i_rden then pops it and o_rdvalid drops to 0.
- Write 10 entries, assert i_flush with i_wren=1 -> o_count=0 and o_empty=1 with no overflow. Separately, async reset mid-burst -> all outputs reach reset values without a clock edge; wrap test: 40 write/read pairs on DEPTH=16 keep data in order.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock elastic buffer with separate read/write
// pointers, an occupancy counter, threshold flags, error pulses, a
// synchronous flush and a selectable first-word-fall-through read port.
module sync_fifo_param #(
    parameter  int DATA_W = 128,
    parameter  int DEPTH  = 1024,
    parameter  int UPP_TH = 4,
    parameter  int LOW_TH = 2,
    parameter  int FWFT   = 0,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_rdvalid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic [CW-1:0]     o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF   = CW'(DEPTH - UPP_TH);
    localparam logic [CW-1:0] C_AE   = CW'(LOW_TH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_rddata;
    logic              r_rdvalid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic [CW-1:0]     w_count_nxt;

    // Flags are pure decodes of the occupancy register.
    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == {CW{1'b0}});

    // A read needs data; a write needs room, or a concurrent read freeing a slot.
    assign w_rd_ok = i_rden & ~w_empty;
    assign w_wr_ok = i_wren & (~w_full | w_rd_ok);

    // Next occupancy: up on a lone write, down on a lone read, else unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; deliberately not reset, flush suppresses the write.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wrdata;
        end
    end

    // Pointers, count and error pulses; flush overrides any request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count     <= w_count_nxt;
            r_overflow  <= i_wren & ~w_wr_ok;
            r_underflow <= i_rden & ~w_rd_ok;
        end
    end

    // Registered read port: the popped word lands here one cycle after the read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rddata  <= {DATA_W{1'b0}};
            r_rdvalid <= 1'b0;
        end else if (i_flush) begin
            r_rdvalid <= 1'b0;
        end else if (w_rd_ok) begin
            r_rddata  <= r_mem[r_rd_ptr];
            r_rdvalid <= 1'b1;
        end else begin
            r_rdvalid <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is visible whenever the FIFO holds data.
            assign o_rddata  = w_empty ? {DATA_W{1'b0}} : r_mem[r_rd_ptr];
            assign o_rdvalid = ~w_empty;
        end else begin : g_reg
            assign o_rddata  = r_rddata;
            assign o_rdvalid = r_rdvalid;
        end
    endgenerate

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count >= C_AF);
    assign o_almost_empty = (r_count <= C_AE);
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a registered-read instance (a_*) and
// an FWFT instance (b_*), both DEPTH=16, DATA_W=8.
module tb_sync_fifo_param;

    logic clk;
    logic reset;

    logic       a_flush, a_wren, a_rden;
    logic [7:0] a_wrdata, a_rddata;
    logic       a_rdvalid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [4:0] a_count;

    logic       b_flush, b_wren, b_rden;
    logic [7:0] b_wrdata, b_rddata;
    logic       b_rdvalid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [4:0] b_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q [$];
    logic [7:0] exp_d;
    logic [7:0] v;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .UPP_TH(4), .LOW_TH(2), .FWFT(0)) u_a (
        .clk(clk), .reset(reset), .i_flush(a_flush), .i_wren(a_wren),
        .i_wrdata(a_wrdata), .i_rden(a_rden), .o_rddata(a_rddata),
        .o_rdvalid(a_rdvalid), .o_full(a_full), .o_empty(a_empty),
        .o_almost_full(a_af), .o_almost_empty(a_ae), .o_count(a_count),
        .o_overflow(a_ovf), .o_underflow(a_udf)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .UPP_TH(4), .LOW_TH(2), .FWFT(1)) u_b (
        .clk(clk), .reset(reset), .i_flush(b_flush), .i_wren(b_wren),
        .i_wrdata(b_wrdata), .i_rden(b_rden), .o_rddata(b_rddata),
        .o_rdvalid(b_rdvalid), .o_full(b_full), .o_empty(b_empty),
        .o_almost_full(b_af), .o_almost_empty(b_ae), .o_count(b_count),
        .o_overflow(b_ovf), .o_underflow(b_udf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        a_flush = 1'b0; a_wren = 1'b0; a_rden = 1'b0; a_wrdata = 8'h00;
        b_flush = 1'b0; b_wren = 1'b0; b_rden = 1'b0; b_wrdata = 8'h00;
        #1;
        // Reset state
        chk("rst_count",  32'(a_count), 32'd0);
        chk("rst_empty",  32'(a_empty), 32'd1);
        chk("rst_ae",     32'(a_ae), 32'd1);
        chk("rst_full",   32'(a_full), 32'd0);
        chk("rst_af",     32'(a_af), 32'd0);
        chk("rst_rdvalid",32'(a_rdvalid), 32'd0);
        chk("rst_rddata", 32'(a_rddata), 32'd0);
        chk("rst_ovf",    32'(a_ovf), 32'd0);
        chk("rst_udf",    32'(a_udf), 32'd0);
        chk("rst_b_rdvalid", 32'(b_rdvalid), 32'd0);
        #12 reset = 1'b1;
        tick();

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            a_wren = 1'b1; a_wrdata = 8'(i);
            tick();
            chk($sformatf("fill_count_%0d", i), 32'(a_count), 32'(i));
            chk($sformatf("fill_af_%0d", i), 32'(a_af), (i >= 12) ? 32'd1 : 32'd0);
            chk($sformatf("fill_full_%0d", i), 32'(a_full), (i == 16) ? 32'd1 : 32'd0);
        end
        // 17th write rejected
        a_wrdata = 8'h77;
        tick();
        chk("ovf_pulse", 32'(a_ovf), 32'd1);
        chk("ovf_count", 32'(a_count), 32'd16);
        a_wren = 1'b0;
        tick();
        chk("ovf_clear", 32'(a_ovf), 32'd0);

        // Full with simultaneous read + write
        a_wren = 1'b1; a_rden = 1'b1; a_wrdata = 8'hAA;
        tick();
        a_wren = 1'b0; a_rden = 1'b0;
        chk("fullrw_count", 32'(a_count), 32'd16);
        chk("fullrw_data",  32'(a_rddata), 32'h01);
        chk("fullrw_valid", 32'(a_rdvalid), 32'd1);
        chk("fullrw_ovf",   32'(a_ovf), 32'd0);

        // Drain: 0x02..0x10 then 0xAA
        for (int i = 0; i < 16; i++) begin
            a_rden = 1'b1;
            tick();
            exp_d = (i < 15) ? 8'(i + 2) : 8'hAA;
            chk($sformatf("drain_data_%0d", i), 32'(a_rddata), 32'(exp_d));
            chk($sformatf("drain_valid_%0d", i), 32'(a_rdvalid), 32'd1);
            chk($sformatf("drain_count_%0d", i), 32'(a_count), 32'(15 - i));
            chk($sformatf("drain_ae_%0d", i), 32'(a_ae), ((15 - i) <= 2) ? 32'd1 : 32'd0);
            chk($sformatf("drain_empty_%0d", i), 32'(a_empty), (i == 15) ? 32'd1 : 32'd0);
        end
        // Read on empty
        tick();
        chk("udf_pulse", 32'(a_udf), 32'd1);
        chk("udf_valid", 32'(a_rdvalid), 32'd0);
        chk("udf_hold",  32'(a_rddata), 32'hAA);
        a_rden = 1'b0;
        tick();
        chk("udf_clear", 32'(a_udf), 32'd0);

        // Empty with simultaneous read + write of 0x55
        a_wren = 1'b1; a_rden = 1'b1; a_wrdata = 8'h55;
        tick();
        a_wren = 1'b0;
        chk("emptyrw_udf",   32'(a_udf), 32'd1);
        chk("emptyrw_count", 32'(a_count), 32'd1);
        chk("emptyrw_nobyp", 32'(a_rdvalid), 32'd0);
        tick();
        a_rden = 1'b0;
        chk("emptyrw_data",  32'(a_rddata), 32'h55);
        chk("emptyrw_valid", 32'(a_rdvalid), 32'd1);
        chk("emptyrw_count2",32'(a_count), 32'd0);

        // Flush with concurrent write
        for (int i = 0; i < 10; i++) begin
            a_wren = 1'b1; a_wrdata = 8'(8'h20 + i);
            tick();
        end
        chk("preflush_count", 32'(a_count), 32'd10);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0; a_wren = 1'b0;
        chk("flush_count", 32'(a_count), 32'd0);
        chk("flush_empty", 32'(a_empty), 32'd1);
        chk("flush_ovf",   32'(a_ovf), 32'd0);
        tick();
        chk("flush_count2", 32'(a_count), 32'd0);
        chk("flush_ovf2",   32'(a_ovf), 32'd0);

        // Wrap: prefill 5, then 40 concurrent write/read pairs, then drain
        for (int i = 0; i < 5; i++) begin
            a_wren = 1'b1; a_wrdata = 8'(8'h80 + i);
            q.push_back(8'(8'h80 + i));
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            v = 8'((i * 13 + 7) & 255);
            a_wren = 1'b1; a_rden = 1'b1; a_wrdata = v;
            tick();
            exp_d = q.pop_front();
            q.push_back(v);
            chk($sformatf("wrap_data_%0d", i), 32'(a_rddata), 32'(exp_d));
            chk($sformatf("wrap_count_%0d", i), 32'(a_count), 32'd5);
        end
        a_wren = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_rden = 1'b1;
            tick();
            exp_d = q.pop_front();
            chk($sformatf("wrapdrain_data_%0d", i), 32'(a_rddata), 32'(exp_d));
        end
        a_rden = 1'b0;
        tick();
        chk("wrap_empty", 32'(a_empty), 32'd1);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) begin
            a_wren = 1'b1; a_wrdata = 8'(8'h40 + i);
            tick();
        end
        a_wren = 1'b1; a_rden = 1'b1; a_wrdata = 8'h4F;
        tick();
        chk("prereset_valid", 32'(a_rdvalid), 32'd1);
        #2 reset = 1'b0;
        a_wren = 1'b0; a_rden = 1'b0;
        #1;
        chk("arst_count",  32'(a_count), 32'd0);
        chk("arst_empty",  32'(a_empty), 32'd1);
        chk("arst_valid",  32'(a_rdvalid), 32'd0);
        chk("arst_rddata", 32'(a_rddata), 32'd0);
        chk("arst_ae",     32'(a_ae), 32'd1);
        #2 reset = 1'b1;
        tick();
        chk("arst_count_after", 32'(a_count), 32'd0);

        // FWFT instance
        b_wren = 1'b1; b_wrdata = 8'h3C;
        tick();
        b_wren = 1'b0;
        chk("fwft_data",  32'(b_rddata), 32'h3C);
        chk("fwft_valid", 32'(b_rdvalid), 32'd1);
        tick();
        chk("fwft_hold",  32'(b_rddata), 32'h3C);
        b_rden = 1'b1;
        tick();
        b_rden = 1'b0;
        chk("fwft_pop_valid", 32'(b_rdvalid), 32'd0);
        chk("fwft_pop_count", 32'(b_count), 32'd0);
        b_wren = 1'b1; b_wrdata = 8'h11;
        tick();
        b_wrdata = 8'h22;
        tick();
        b_wren = 1'b0;
        chk("fwft_head1", 32'(b_rddata), 32'h11);
        b_rden = 1'b1;
        tick();
        chk("fwft_head2",  32'(b_rddata), 32'h22);
        chk("fwft_valid2", 32'(b_rdvalid), 32'd1);
        tick();
        b_rden = 1'b0;
        chk("fwft_valid3", 32'(b_rdvalid), 32'd0);
        chk("fwft_udf0",   32'(b_udf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
